// File: rtl/alu_frame_sequencer.sv
// Sequences UART command frames (header, A, opcode, B) into the ALU and hands the result to the UART transmitter.
// Registered outputs; includes header sync, inter-byte timeout, overrun detection and frame/error counters.
module alu_frame_sequencer #(
  parameter int WIDTH_WORD_INTERFACE  = 8,
  parameter int CANT_DATOS_ENTRADA_ALU = 8,
  parameter int CANT_BITS_OPCODE_ALU  = 8,
  parameter int CANT_DATOS_SALIDA_ALU = 8,
  parameter logic [WIDTH_WORD_INTERFACE-1:0] HEADER_BYTE = 8'hA5,
  parameter int LATENCIA_ALU          = 1,
  parameter int TIMEOUT_CICLOS        = 50000
) (
  input  logic                              i_clock,
  input  logic                              i_reset,
  input  logic [WIDTH_WORD_INTERFACE-1:0]   i_data_rx,
  input  logic                              i_rx_done,
  input  logic                              i_tx_done,
  input  logic [CANT_DATOS_SALIDA_ALU-1:0]  i_resultado_alu,
  output logic [CANT_DATOS_ENTRADA_ALU-1:0] o_reg_dato_A,
  output logic [CANT_DATOS_ENTRADA_ALU-1:0] o_reg_dato_B,
  output logic [CANT_BITS_OPCODE_ALU-1:0]   o_reg_opcode,
  output logic [WIDTH_WORD_INTERFACE-1:0]   o_data_tx,
  output logic                              o_tx_start,
  output logic                              o_busy,
  output logic                              o_timeout,
  output logic                              o_overrun,
  output logic [7:0]                        o_frame_count,
  output logic [7:0]                        o_error_count
);

  localparam int TO_W  = (TIMEOUT_CICLOS > 2) ? $clog2(TIMEOUT_CICLOS) : 1;
  localparam int LAT_W = (LATENCIA_ALU > 1) ? $clog2(LATENCIA_ALU) : 1;

  typedef enum logic [2:0] {
    ESPERA,
    OPERANDO1,
    OPERACION,
    OPERANDO2,
    EJECUTAR,
    TRANSMITIR
  } state_t;

  state_t                            state_q, state_d;
  logic [TO_W-1:0]                   to_cnt_q, to_cnt_d;
  logic [LAT_W-1:0]                  lat_cnt_q, lat_cnt_d;
  logic [CANT_DATOS_ENTRADA_ALU-1:0] dato_a_q, dato_a_d;
  logic [CANT_DATOS_ENTRADA_ALU-1:0] dato_b_q, dato_b_d;
  logic [CANT_BITS_OPCODE_ALU-1:0]   opcode_q, opcode_d;
  logic [WIDTH_WORD_INTERFACE-1:0]   data_tx_q, data_tx_d;
  logic                              tx_start_q, tx_start_d;
  logic                              busy_q, busy_d;
  logic                              timeout_q, timeout_d;
  logic                              overrun_q, overrun_d;
  logic [7:0]                        frame_cnt_q, frame_cnt_d;
  logic [7:0]                        err_cnt_q, err_cnt_d;
  logic                              err_inc;

  always_comb begin
    state_d     = state_q;
    to_cnt_d    = to_cnt_q;
    lat_cnt_d   = lat_cnt_q;
    dato_a_d    = dato_a_q;
    dato_b_d    = dato_b_q;
    opcode_d    = opcode_q;
    data_tx_d   = data_tx_q;
    tx_start_d  = 1'b0;
    timeout_d   = 1'b0;
    overrun_d   = 1'b0;
    frame_cnt_d = frame_cnt_q;
    err_inc     = 1'b0;

    case (state_q)
      ESPERA: begin
        if (i_rx_done && (i_data_rx == HEADER_BYTE)) begin
          state_d  = OPERANDO1;
          to_cnt_d = '0;
        end
      end
      OPERANDO1, OPERACION, OPERANDO2: begin
        // A byte arriving on the expiry cycle is accepted; it beats the timeout.
        if (i_rx_done) begin
          to_cnt_d = '0;
          if (state_q == OPERANDO1) begin
            dato_a_d = i_data_rx[CANT_DATOS_ENTRADA_ALU-1:0];
            state_d  = OPERACION;
          end else if (state_q == OPERACION) begin
            opcode_d = i_data_rx[CANT_BITS_OPCODE_ALU-1:0];
            state_d  = OPERANDO2;
          end else begin
            dato_b_d  = i_data_rx[CANT_DATOS_ENTRADA_ALU-1:0];
            lat_cnt_d = '0;
            state_d   = EJECUTAR;
          end
        end else if (to_cnt_q == TO_W'(TIMEOUT_CICLOS - 2)) begin
          timeout_d = 1'b1;
          err_inc   = 1'b1;
          to_cnt_d  = '0;
          state_d   = ESPERA;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      EJECUTAR: begin
        if (i_rx_done) begin
          overrun_d = 1'b1;
          err_inc   = 1'b1;
        end
        if (lat_cnt_q == LAT_W'(LATENCIA_ALU - 1)) begin
          data_tx_d  = WIDTH_WORD_INTERFACE'(i_resultado_alu);
          tx_start_d = 1'b1;
          state_d    = TRANSMITIR;
        end else begin
          lat_cnt_d = lat_cnt_q + LAT_W'(1);
        end
      end
      TRANSMITIR: begin
        if (i_rx_done) begin
          overrun_d = 1'b1;
          err_inc   = 1'b1;
        end
        if (i_tx_done) begin
          frame_cnt_d = frame_cnt_q + 8'd1;
          state_d     = ESPERA;
        end
      end
      default: state_d = ESPERA;
    endcase

    err_cnt_d = (err_inc && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
    busy_d    = (state_d != ESPERA);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q     <= ESPERA;
      to_cnt_q    <= '0;
      lat_cnt_q   <= '0;
      dato_a_q    <= '0;
      dato_b_q    <= '0;
      opcode_q    <= '0;
      data_tx_q   <= '0;
      tx_start_q  <= 1'b0;
      busy_q      <= 1'b0;
      timeout_q   <= 1'b0;
      overrun_q   <= 1'b0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      to_cnt_q    <= to_cnt_d;
      lat_cnt_q   <= lat_cnt_d;
      dato_a_q    <= dato_a_d;
      dato_b_q    <= dato_b_d;
      opcode_q    <= opcode_d;
      data_tx_q   <= data_tx_d;
      tx_start_q  <= tx_start_d;
      busy_q      <= busy_d;
      timeout_q   <= timeout_d;
      overrun_q   <= overrun_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign o_reg_dato_A  = dato_a_q;
  assign o_reg_dato_B  = dato_b_q;
  assign o_reg_opcode  = opcode_q;
  assign o_data_tx     = data_tx_q;
  assign o_tx_start    = tx_start_q;
  assign o_busy        = busy_q;
  assign o_timeout     = timeout_q;
  assign o_overrun     = overrun_q;
  assign o_frame_count = frame_cnt_q;
  assign o_error_count = err_cnt_q;

endmodule

// File: tb/tb_alu_frame_sequencer.sv
// Directed plus randomized frames against a transaction-level model of the frame protocol; the ALU is modelled as A+B.
module tb_alu_frame_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_rx;
  logic       rx_done;
  logic       tx_done;
  logic [7:0] resultado;
  logic [7:0] dato_a, dato_b, opcode, data_tx;
  logic       tx_start, busy, timeout, overrun;
  logic [7:0] frame_count, error_count;

  int checks = 0;
  int errors = 0;

  // Expected state kept at transaction level
  logic [7:0] exp_frames;
  logic [7:0] exp_errs;
  logic [7:0] exp_tx;

  always #5 clk = ~clk;

  assign resultado = dato_a + dato_b;

  alu_frame_sequencer #(
    .WIDTH_WORD_INTERFACE  (8),
    .CANT_DATOS_ENTRADA_ALU(8),
    .CANT_BITS_OPCODE_ALU  (8),
    .CANT_DATOS_SALIDA_ALU (8),
    .HEADER_BYTE           (8'hA5),
    .LATENCIA_ALU          (1),
    .TIMEOUT_CICLOS        (16)
  ) dut (
    .i_clock        (clk),
    .i_reset        (rst),
    .i_data_rx      (data_rx),
    .i_rx_done      (rx_done),
    .i_tx_done      (tx_done),
    .i_resultado_alu(resultado),
    .o_reg_dato_A   (dato_a),
    .o_reg_dato_B   (dato_b),
    .o_reg_opcode   (opcode),
    .o_data_tx      (data_tx),
    .o_tx_start     (tx_start),
    .o_busy         (busy),
    .o_timeout      (timeout),
    .o_overrun      (overrun),
    .o_frame_count  (frame_count),
    .o_error_count  (error_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    data_rx = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  function automatic logic [7:0] err_sat_inc(input logic [7:0] e);
    return (e == 8'hFF) ? e : e + 8'd1;
  endfunction

  task automatic do_frame(input logic [7:0] a, input logic [7:0] op, input logic [7:0] b,
                          input int gap, input bit ovr);
    send(8'hA5); idle(gap);
    send(a);     idle(gap);
    send(op);    idle(gap);
    send(b);
    chk("opA", dato_a, a);
    chk("opcode", opcode, op);
    chk("opB", dato_b, b);
    chk("no_early_start", tx_start, 0);
    @(negedge clk);
    exp_tx = a + b;
    chk("tx_start", tx_start, 1);
    chk("tx_byte", data_tx, exp_tx);
    if (ovr) begin
      send(8'hFF);
      exp_errs = err_sat_inc(exp_errs);
      chk("overrun", overrun, 1);
      chk("tx_held", data_tx, exp_tx);
    end else begin
      @(negedge clk);
      chk("no_overrun", overrun, 0);
    end
    chk("start_pulse", tx_start, 0);
    chk("busy_tx", busy, 1);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    exp_frames = exp_frames + 8'd1;
    chk("frames", frame_count, exp_frames);
    chk("idle", busy, 0);
    chk("errs", error_count, exp_errs);
  endtask

  task automatic do_timeout(input int nbytes);
    bit early;
    send(8'hA5);
    for (int i = 0; i < nbytes; i++) send(8'($urandom));
    early = 1'b0;
    repeat (14) begin
      @(negedge clk);
      if (timeout !== 1'b0) early = 1'b1;
    end
    chk("to_not_early", early, 0);
    @(negedge clk);
    exp_errs = err_sat_inc(exp_errs);
    chk("timeout", timeout, 1);
    chk("to_idle", busy, 0);
    chk("to_errs", error_count, exp_errs);
    @(negedge clk);
    chk("to_pulse", timeout, 0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_frames = 8'd0;
    exp_errs   = 8'd0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_A"}, dato_a, 0);
    chk({tag, "_B"}, dato_b, 0);
    chk({tag, "_op"}, opcode, 0);
    chk({tag, "_tx"}, data_tx, 0);
    chk({tag, "_flags"}, {tx_start, busy, timeout, overrun}, 0);
    chk({tag, "_cnt"}, {frame_count, error_count}, 0);
  endtask

  initial begin
    logic [7:0] a, op, b;
    rst = 1'b1; rx_done = 1'b0; tx_done = 1'b0; data_rx = 8'h00;
    exp_frames = 8'd0; exp_errs = 8'd0; exp_tx = 8'd0;
    idle(2);
    rst = 1'b0;
    chk_all_zero("reset");

    // Nominal frame
    do_frame(8'h03, 8'h20, 8'h05, 0, 1'b0);
    chk("nominal_tx", data_tx, 8'h08);

    // Junk before header is discarded silently
    send(8'h11); send(8'h22);
    chk("junk_idle", busy, 0);
    do_frame(8'h01, 8'h20, 8'h01, 1, 1'b0);
    chk("junk_tx", data_tx, 8'h02);
    chk("junk_errs", error_count, 0);

    // Header value inside the frame is plain data
    do_frame(8'hA5, 8'hA5, 8'hA5, 0, 1'b0);

    // Stray tx_done while idle
    tx_done = 1'b1; @(negedge clk); tx_done = 1'b0;
    chk("stray_txdone", frame_count, exp_frames);

    // Timeout after A5, 07
    send(8'hA5); send(8'h07);
    begin
      bit early = 1'b0;
      repeat (14) begin
        @(negedge clk);
        if (timeout !== 1'b0) early = 1'b1;
      end
      chk("to07_not_early", early, 0);
    end
    @(negedge clk);
    exp_errs = err_sat_inc(exp_errs);
    chk("to07_pulse", timeout, 1);
    chk("to07_idle", busy, 0);
    chk("to07_errs", error_count, 1);
    chk("to07_A_held", dato_a, 8'h07);

    // Overrun during TRANSMITIR
    do_frame(8'h10, 8'h20, 8'h22, 0, 1'b1);
    chk("ovr_errs", error_count, 2);

    // Reset mid-frame
    send(8'hA5); send(8'h09);
    pulse_reset();
    chk_all_zero("midreset");
    do_frame(8'h01, 8'h20, 8'h02, 0, 1'b0);
    chk("post_reset_tx", data_tx, 8'h03);

    // Frame counter wrap over 256 random frames
    pulse_reset();
    for (int i = 0; i < 256; i++) begin
      a  = 8'($urandom);
      op = 8'($urandom);
      b  = 8'($urandom);
      do_frame(a, op, b, $urandom_range(0, 8), 1'($urandom_range(0, 3) == 0));
    end
    chk("frame_wrap", frame_count, 0);

    // Error counter saturation
    pulse_reset();
    for (int i = 0; i < 300; i++) do_timeout($urandom_range(0, 2));
    chk("err_sat", error_count, 8'hFF);
    chk("err_sat_model", exp_errs, error_count);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_frame_sequencer.md
Name: alu_frame_sequencer

Overview:
Controller that sequences the UART-to-ALU datapath. It receives a 4-byte command frame from the UART receiver: header, operand A, opcode, operand B. It holds the ALU operands and opcode stable, waits a fixed ALU latency, then hands the result byte to the UART transmitter with a start/done handshake. It adds header sync, an inter-byte timeout, overrun detection and frame/error counters.

Parameters:
WIDTH_WORD_INTERFACE, 8, UART byte width
CANT_DATOS_ENTRADA_ALU, 8, ALU operand width (must be <= WIDTH_WORD_INTERFACE; low bits of the rx byte are used)
CANT_BITS_OPCODE_ALU, 8, ALU opcode width (low bits of the rx byte are used)
CANT_DATOS_SALIDA_ALU, 8, ALU result width (zero-extended to the tx byte)
HEADER_BYTE, 8'hA5, frame start marker
LATENCIA_ALU, 1, cycles from last operand capture to result sample (>=1)
TIMEOUT_CICLOS, 50000, max idle cycles between bytes inside a frame (>=2)

Ports:
i_clock  in  1  system clock
i_reset  in  1  synchronous reset, active-high
i_data_rx  in  WIDTH_WORD_INTERFACE  received byte, valid when i_rx_done=1
i_rx_done  in  1  one-cycle pulse, byte received
i_tx_done  in  1  one-cycle pulse, transmitter finished byte
i_resultado_alu  in  CANT_DATOS_SALIDA_ALU  ALU result
o_reg_dato_A  out  CANT_DATOS_ENTRADA_ALU  ALU operand A
o_reg_dato_B  out  CANT_DATOS_ENTRADA_ALU  ALU operand B
o_reg_opcode  out  CANT_BITS_OPCODE_ALU  ALU opcode
o_data_tx  out  WIDTH_WORD_INTERFACE  byte to transmit
o_tx_start  out  1  one-cycle pulse, start transmission
o_busy  out  1  high in any state other than ESPERA
o_timeout  out  1  one-cycle pulse on frame abort by timeout
o_overrun  out  1  one-cycle pulse when a byte arrives in EJECUTAR/TRANSMITIR
o_frame_count  out  8  completed frames, wraps 255->0
o_error_count  out  8  timeouts + overruns, saturates at 255

Behaviour:
- One clock, i_clock. Synchronous active-high reset i_reset. All outputs are registered.
- Reset: every output = 0, state = ESPERA, timeout counter = 0, latency counter = 0. Reset wins over all other events, including mid-frame and mid-transmission.
- States: ESPERA, OPERANDO1, OPERACION, OPERANDO2, EJECUTAR, TRANSMITIR.
- ESPERA:
  - rx_done with data == HEADER_BYTE -> OPERANDO1.
  - Any other byte is silently discarded. It is not an error.
- OPERANDO1: rx_done -> o_reg_dato_A <= data; go to OPERACION.
- OPERACION: rx_done -> o_reg_opcode <= data; go to OPERANDO2.
- OPERANDO2: rx_done -> o_reg_dato_B <= data; latency counter = 0; go to EJECUTAR.
- Header value inside the frame: a byte equal to HEADER_BYTE in OPERANDO1/OPERACION/OPERANDO2 is treated as data, not resync.
- EJECUTAR:
  - Counts LATENCIA_ALU cycles.
  - On the last cycle: o_data_tx <= zero-extended i_resultado_alu, o_tx_start = 1 for exactly one cycle, go to TRANSMITIR.
  - With LATENCIA_ALU=1, o_tx_start is asserted in the cycle after the OPERANDO2 capture edge.
- TRANSMITIR: i_tx_done -> o_frame_count++ and go to ESPERA.
- Stray i_tx_done outside TRANSMITIR is ignored.
- Held values: operands, opcode and o_data_tx keep their values until overwritten by the next frame. They are not cleared by timeout.
- Timeout:
  - A counter runs in OPERANDO1/OPERACION/OPERANDO2 and clears on every rx_done and on every state entry.
  - On reaching TIMEOUT_CICLOS-1 without rx_done: o_timeout pulses, o_error_count++ (saturating), go to ESPERA.
  - If rx_done and timeout expiry coincide, the byte wins: it is accepted and there is no timeout.
- Overrun: rx_done in EJECUTAR or TRANSMITIR -> byte dropped, o_overrun pulse, o_error_count++ (saturating). The state is unaffected.
- Simultaneous events:
  - o_timeout and o_overrun can never coincide.
  - o_error_count increments by at most 1 per cycle.

Test Plan:
- Nominal frame: rx A5, 03, 20, 05 with ALU model result=A+B -> o_reg_dato_A=03, o_reg_opcode=20, o_reg_dato_B=05, one-cycle o_tx_start with o_data_tx=08; after tx_done, o_frame_count=1, o_busy=0.
- Junk before header: rx 11, 22, A5, 01, 20, 01 -> junk ignored, o_error_count=0, tx byte=02.
- Timeout (TIMEOUT_CICLOS=16): rx A5, 07, then silence -> o_timeout pulses 15 cycles after the 07 capture; state ESPERA; o_error_count=1; o_reg_dato_A stays 07.
- Overrun: full frame, then rx FF while in TRANSMITIR -> o_overrun pulse, o_error_count=1, o_data_tx unchanged, frame still completes.
- Reset mid-frame: rx A5, 09, assert i_reset one cycle -> all outputs 0, o_busy=0; a following frame A5,01,20,02 yields tx byte 03.
- Error count saturation and frame count wrap: 256 frames -> o_frame_count=0; 300 timeouts -> o_error_count=255.
